// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for 640x480 @ 60 Hz VGA, derived from the 100 MHz
// system clock by an integer divider. Produces the pixel coordinates used by
// the renderers, the active-low sync pulses, the video-active qualifier and
// per-pixel / per-line / per-frame strobes. All outputs are registered.
//
// Ports:
//   clk         in   system clock (100 MHz)
//   reset       in   asynchronous active-high reset
//   p_tick      out  one-clk pixel advance strobe
//   p_col       out  horizontal count, 0..H_TOTAL-1
//   p_row       out  vertical count, 0..V_TOTAL-1
//   hsync       out  active-low horizontal sync
//   vsync       out  active-low vertical sync
//   video_on    out  high while (p_col, p_row) is inside the visible area
//   line_end    out  one-clk pulse when p_col wraps to 0
//   frame_start out  one-clk pulse when (p_row, p_col) wraps to (0, 0)
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] p_col,
    output logic [9:0] p_row,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_end,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits wide so an end bound of 1024 cannot alias to 0.
    localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_cnt_q,     div_cnt_d;
    logic       p_tick_q,      p_tick_d;
    logic [9:0] col_q,         col_d;
    logic [9:0] row_q,         row_d;
    logic       hsync_q,       hsync_d;
    logic       vsync_q,       vsync_d;
    logic       video_on_q,    video_on_d;
    logic       line_end_q,    line_end_d;
    logic       frame_start_q, frame_start_d;

    // Next-state logic: divider, raster counters, and decodes of the next coordinates.
    always_comb begin
        div_cnt_d     = div_cnt_q;
        p_tick_d      = 1'b0;
        col_d         = col_q;
        row_d         = row_q;
        line_end_d    = 1'b0;
        frame_start_d = 1'b0;

        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = 4'd0;
            p_tick_d  = 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 4'd1;
            p_tick_d  = 1'b0;
        end

        // The counters advance in the clock after the strobe is registered,
        // so coordinates change one clock after p_tick is seen high.
        if (p_tick_q) begin
            if (col_q == H_LAST) begin
                col_d      = 10'd0;
                line_end_d = 1'b1;
                if (row_q == V_LAST) begin
                    row_d         = 10'd0;
                    frame_start_d = 1'b1;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end

        // Decoding the next-state coordinates keeps the registered qualifiers
        // aligned with the coordinates they describe.
        hsync_d    = !(({1'b0, col_d} >= HS_START) && ({1'b0, col_d} < HS_END));
        vsync_d    = !(({1'b0, row_d} >= VS_START) && ({1'b0, row_d} < VS_END));
        video_on_d = ({1'b0, col_d} < H_ACT_END) && ({1'b0, row_d} < V_ACT_END);
    end

    // State and output registers with asynchronous reset to the (0,0) raster state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt_q     <= 4'd0;
            p_tick_q      <= 1'b0;
            col_q         <= 10'd0;
            row_q         <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b1;
            line_end_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            p_tick_q      <= p_tick_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_end_q    <= line_end_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign p_tick      = p_tick_q;
    assign p_col       = col_q;
    assign p_row       = row_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_end    = line_end_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-parameter instance and a small-raster
// instance (CLK_DIV=1, 12x7 raster), each reset at random moments. Expected
// outputs come from an arithmetic raster model indexed by clocks since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       tick;
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       von;
        logic       le;
        logic       fs;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    logic       a_tick, a_hs, a_vs, a_von, a_le, a_fs;
    logic [9:0] a_col, a_row;
    logic       b_tick, b_hs, b_vs, b_von, b_le, b_fs;
    logic [9:0] b_col, b_row;

    obs_t act_a, act_b;
    assign act_a = {a_tick, a_col, a_row, a_hs, a_vs, a_von, a_le, a_fs};
    assign act_b = {b_tick, b_col, b_row, b_hs, b_vs, b_von, b_le, b_fs};

    obs_t sb_a[$];
    obs_t sb_b[$];
    event async_a, async_b;

    int checks = 0;
    int failures = 0;
    int pushed_a = 0, popped_a = 0, pushed_b = 0, popped_b = 0;
    int exp_le_a = 0, obs_le_a = 0, exp_fs_b = 0, obs_fs_b = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .reset(rst_a), .p_tick(a_tick), .p_col(a_col), .p_row(a_row),
        .hsync(a_hs), .vsync(a_vs), .video_on(a_von), .line_end(a_le), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_b (
        .clk(clk), .reset(rst_b), .p_tick(b_tick), .p_col(b_col), .p_row(b_row),
        .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .line_end(b_le), .frame_start(b_fs)
    );

    // Reference raster: n = rising edges seen with reset low since the last reset.
    // Pixel k starts at edge k*D+1; coordinates follow from k by division.
    function automatic obs_t model(input int id, input int n);
        int d, ha, hf, hsw, hb, va, vf, vsw, vb, ht, vt, k, col, row;
        obs_t e;
        if (id == 0) begin
            d = 4; ha = 640; hf = 16; hsw = 96; hb = 48; va = 480; vf = 10; vsw = 2; vb = 33;
        end else begin
            d = 1; ha = 8; hf = 1; hsw = 2; hb = 1; va = 4; vf = 1; vsw = 1; vb = 1;
        end
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        k   = (n == 0) ? 0 : (n - 1) / d;
        col = k % ht;
        row = (k / ht) % vt;
        e.tick = (n >= d) && (n % d == 0);
        e.col  = 10'(col);
        e.row  = 10'(row);
        e.hs   = !((col >= ha + hf) && (col < ha + hf + hsw));
        e.vs   = !((row >= va + vf) && (row < va + vf + vsw));
        e.von  = (col < ha) && (row < va);
        e.le   = (k > 0) && (col == 0) && ((n - 1) % d == 0);
        e.fs   = e.le && (row == 0);
        return e;
    endfunction

    function automatic void check_obs(input string name, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s t=%0t actual tick=%0b col=%0d row=%0d hs=%0b vs=%0b von=%0b le=%0b fs=%0b required tick=%0b col=%0d row=%0d hs=%0b vs=%0b von=%0b le=%0b fs=%0b",
                         name, $time, a.tick, a.col, a.row, a.hs, a.vs, a.von, a.le, a.fs,
                         e.tick, e.col, e.row, e.hs, e.vs, e.von, e.le, e.fs);
        end
    endfunction

    function automatic void check_int(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, a, e);
        end
    endfunction

    task automatic set_rst(input int id, input logic v);
        if (id == 0) rst_a = v;
        else         rst_b = v;
    endtask

    task automatic push(input int id, input obs_t e);
        if (id == 0) begin sb_a.push_back(e); pushed_a++; end
        else         begin sb_b.push_back(e); pushed_b++; end
    endtask

    // Stimulus: runs the clock count, injects resets between edges, and pushes
    // the model's expectation for every clock plus each asynchronous assertion.
    task automatic drive(input int id, input int cycles, input int gap_lo, input int gap_hi,
                         input int hold_lo, input int hold_hi);
        int  n = 0;
        int  rel_at = 3;
        int  next_rst = cycles + 1;
        bit  in_rst = 1'b1;
        set_rst(id, 1'b1);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            if (in_rst) n = 0;
            else        n++;
            push(id, model(id, n));
            if (in_rst && c == rel_at) begin
                @(negedge clk);
                #1;
                set_rst(id, 1'b0);
                in_rst   = 1'b0;
                next_rst = c + int'($urandom_range(gap_hi, gap_lo));
            end else if (!in_rst && c == next_rst) begin
                @(negedge clk);
                #1;
                set_rst(id, 1'b1);
                in_rst = 1'b1;
                #1;
                push(id, model(id, 0));
                if (id == 0) -> async_a;
                else         -> async_b;
                rel_at = c + int'($urandom_range(hold_hi, hold_lo));
            end
        end
    endtask

    // Monitor: pops one expectation per clock (and per async reset event) and compares.
    task automatic monitor(input int id);
        obs_t e;
        obs_t a;
        forever begin
            if (id == 0) @(negedge clk or async_a);
            else         @(negedge clk or async_b);
            if (id == 0 && sb_a.size() > 0) begin
                e = sb_a.pop_front();
                popped_a++;
                a = act_a;
                if (e.le) exp_le_a++;
                if (a.le) obs_le_a++;
                check_obs("inst_a", a, e);
            end else if (id == 1 && sb_b.size() > 0) begin
                e = sb_b.pop_front();
                popped_b++;
                a = act_b;
                if (e.fs) exp_fs_b++;
                if (a.fs) obs_fs_b++;
                check_obs("inst_b", a, e);
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
        join_none
        fork
            drive(0, 14000, 7000, 8500, 3, 3);
            drive(1, 14000, 150, 600, 1, 5);
        join
        @(negedge clk);
        #3;
        check_int("drain_a", popped_a, pushed_a);
        check_int("drain_b", popped_b, pushed_b);
        check_int("line_end_count_a", obs_le_a, exp_le_a);
        check_int("frame_start_count_b", obs_fs_b, exp_fs_b);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
